// File: rtl/mem_wb_stage_pkg.sv
// Shared opcode and FSM encodings for the memory / write-back stage.
// Contents: 5-bit opcode constants, MEM_WB FSM state type, decode helpers.
package mem_wb_stage_pkg;

   localparam int unsigned OP_W    = 5;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_W   = 4;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned TMO_W   = 4;

   // ALU opcodes occupy the contiguous range (OP_NOP, OP_ARSH].
   localparam logic [OP_W-1:0] OP_NOP  = 5'd0;
   localparam logic [OP_W-1:0] OP_ADD  = 5'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 5'd2;
   localparam logic [OP_W-1:0] OP_AND  = 5'd3;
   localparam logic [OP_W-1:0] OP_OR   = 5'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
   localparam logic [OP_W-1:0] OP_LSH  = 5'd6;
   localparam logic [OP_W-1:0] OP_RSH  = 5'd7;
   localparam logic [OP_W-1:0] OP_ARSH = 5'd8;
   localparam logic [OP_W-1:0] OP_LDW  = 5'd9;
   localparam logic [OP_W-1:0] OP_STR  = 5'd10;
   localparam logic [OP_W-1:0] OP_CMP  = 5'd11;
   localparam logic [OP_W-1:0] OP_BRQ  = 5'd12;
   localparam logic [OP_W-1:0] OP_BRG  = 5'd13;
   localparam logic [OP_W-1:0] OP_BRS  = 5'd14;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_WB       = 2'd2
   } mem_wb_state_t;

   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return (op > OP_NOP) && (op <= OP_ARSH);
   endfunction

   // Opcodes that write the register file one cycle after acceptance.
   function automatic logic is_direct_write(input logic [OP_W-1:0] op,
                                            input logic            isimm);
      return is_alu(op) || (op == OP_CMP) || ((op == OP_LDW) && isimm);
   endfunction

   // Opcodes that need a data-memory transaction.
   function automatic logic is_mem_op(input logic [OP_W-1:0] op,
                                      input logic            isimm);
      return ((op == OP_LDW) && !isimm) || (op == OP_STR);
   endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage.
// Accepts execute-stage results in IDLE, writes ALU/CMP/immediate-load
// results straight to the register file, and runs one data-memory
// transaction for LDW (non-immediate) and STR, stalling upstream meanwhile.
// Ports: clk, rst (sync, active-high); in_* execute-stage result;
// stall (combinational); mem_* data-memory request/response;
// rf_* register-file write port; status_ovf/status_err/bus_error sticky flags.
// Optional: define PIGRO_MEM_TIMEOUT_EN to abort a memory access after
// 16 cycles without ack and raise bus_error.
module mem_wb_stage
   import mem_wb_stage_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [OP_W-1:0]          in_opcode,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic [REG_W-1:0]         in_dest,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     in_isimm,
   input  logic                     in_overflow,
   input  logic                     in_error,
   output logic                     stall,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack,
   output logic                     rf_we,
   output logic [REG_W-1:0]         rf_waddr,
   output logic [DATA_W-1:0]        rf_wdata,
   output logic                     status_ovf,
   output logic                     status_err,
   output logic                     bus_error
);

   mem_wb_state_t    state;
   logic             pend_load;
   logic [REG_W-1:0] pend_dest;

`ifdef PIGRO_MEM_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = '1;
   logic [TMO_W-1:0] tmo_cnt;
`else
   assign bus_error = 1'b0;
`endif

   // Upstream must hold while busy or while a memory op is being accepted.
   assign stall = (state != ST_IDLE) || (in_valid && is_mem_op(in_opcode, in_isimm));

   // Stage FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pend_load  <= 1'b0;
         pend_dest  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         status_ovf <= 1'b0;
         status_err <= 1'b0;
`ifdef PIGRO_MEM_TIMEOUT_EN
         tmo_cnt    <= '0;
         bus_error  <= 1'b0;
`endif
      end else begin
         rf_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (is_direct_write(in_opcode, in_isimm)) begin
                     rf_we    <= 1'b1;
                     rf_waddr <= in_dest;
                     rf_wdata <= in_data;
                  end
                  if (is_alu(in_opcode)) begin
                     if (in_overflow) status_ovf <= 1'b1;
                     if (in_error)    status_err <= 1'b1;
                  end
                  if (is_mem_op(in_opcode, in_isimm)) begin
                     mem_req   <= 1'b1;
                     mem_we    <= (in_opcode == OP_STR);
                     mem_addr  <= in_addr;
                     if (in_opcode == OP_STR) mem_wdata <= in_data;
                     pend_load <= (in_opcode == OP_LDW);
                     pend_dest <= in_dest;
                     state     <= ST_MEM_WAIT;
`ifdef PIGRO_MEM_TIMEOUT_EN
                     tmo_cnt   <= '0;
`endif
                  end
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (pend_load) begin
                     rf_we    <= 1'b1;
                     rf_waddr <= pend_dest;
                     rf_wdata <= mem_rdata;
                     state    <= ST_WB;
                  end else begin
                     state    <= ST_IDLE;
                  end
               end
`ifdef PIGRO_MEM_TIMEOUT_EN
               // 16th cycle without ack: abandon the access.
               else if (tmo_cnt == TMO_LAST) begin
                  mem_req   <= 1'b0;
                  bus_error <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            // rf_we is high during this cycle; just return to IDLE.
            ST_WB:   state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;
   import mem_wb_stage_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic [OP_W-1:0]          in_opcode;
   logic signed [DATA_W-1:0] in_data;
   logic [REG_W-1:0]         in_dest;
   logic [ADDR_W-1:0]        in_addr;
   logic                     in_isimm;
   logic                     in_overflow;
   logic                     in_error;
   logic                     stall;
   logic                     mem_req;
   logic                     mem_we;
   logic [ADDR_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic [DATA_W-1:0]        mem_rdata;
   logic                     mem_ack;
   logic                     rf_we;
   logic [REG_W-1:0]         rf_waddr;
   logic [DATA_W-1:0]        rf_wdata;
   logic                     status_ovf;
   logic                     status_err;
   logic                     bus_error;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
      .in_data(in_data), .in_dest(in_dest), .in_addr(in_addr),
      .in_isimm(in_isimm), .in_overflow(in_overflow), .in_error(in_error),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .status_ovf(status_ovf), .status_err(status_err), .bus_error(bus_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one clock; land 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [OP_W-1:0] op, input logic [31:0] d,
                        input logic [REG_W-1:0] dst, input logic [ADDR_W-1:0] a,
                        input logic imm, input logic ovf, input logic err);
      in_valid = v; in_opcode = op; in_data = d; in_dest = dst; in_addr = a;
      in_isimm = imm; in_overflow = ovf; in_error = err;
   endtask

   task automatic idle_in();
      drive(1'b0, OP_NOP, 32'h0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
      idle_in();
      tick(); tick();
      rst = 1'b0;
      #1;
      // Reset state
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_rf_we", rf_we, 1'b0);
      chk ("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk ("rst_mem_wdata", mem_wdata, 32'h0);
      chk ("rst_rf_waddr", 32'(rf_waddr), 32'h0);
      chk ("rst_rf_wdata", rf_wdata, 32'h0);
      chk1("rst_ovf", status_ovf, 1'b0);
      chk1("rst_err", status_err, 1'b0);
      chk1("rst_bus_error", bus_error, 1'b0);
      chk1("rst_stall", stall, 1'b0);

      // ADD r3 = 5
      drive(1'b1, OP_ADD, 32'h0000_0005, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
      #1 chk1("add_stall_in", stall, 1'b0);
      tick();
      idle_in();
      chk1("add_rf_we", rf_we, 1'b1);
      chk ("add_rf_waddr", 32'(rf_waddr), 32'd3);
      chk ("add_rf_wdata", rf_wdata, 32'd5);
      chk1("add_stall_out", stall, 1'b0);
      tick();
      chk1("add_rf_we_pulse", rf_we, 1'b0);

      // LDW r7 <- [0x10], ack during the third request cycle
      drive(1'b1, OP_LDW, 32'h0, 4'd7, 8'h10, 1'b0, 1'b0, 1'b0);
      #1 chk1("ldw_stall_present", stall, 1'b1);
      tick();
      idle_in();
      chk1("ldw_req_c1", mem_req, 1'b1);
      chk1("ldw_we", mem_we, 1'b0);
      chk ("ldw_addr", 32'(mem_addr), 32'h10);
      chk1("ldw_stall_c1", stall, 1'b1);
      tick();
      chk1("ldw_req_c2", mem_req, 1'b1);
      chk1("ldw_rf_we_c2", rf_we, 1'b0);
      tick();
      chk1("ldw_req_c3", mem_req, 1'b1);
      chk ("ldw_addr_hold", 32'(mem_addr), 32'h10);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      chk1("ldw_req_drop", mem_req, 1'b0);
      chk1("ldw_rf_we", rf_we, 1'b1);
      chk ("ldw_rf_waddr", 32'(rf_waddr), 32'd7);
      chk ("ldw_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk1("ldw_stall_wb", stall, 1'b1);
      tick();
      chk1("ldw_rf_we_pulse", rf_we, 1'b0);
      chk1("ldw_stall_done", stall, 1'b0);

      // STR -1 -> [0x22], ack in the first request cycle
      drive(1'b1, OP_STR, 32'hFFFF_FFFF, 4'd1, 8'h22, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      chk1("str_req", mem_req, 1'b1);
      chk1("str_we", mem_we, 1'b1);
      chk ("str_addr", 32'(mem_addr), 32'h22);
      chk ("str_wdata", mem_wdata, 32'hFFFF_FFFF);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk1("str_req_drop", mem_req, 1'b0);
      chk1("str_no_rf_we", rf_we, 1'b0);
      chk1("str_stall_idle", stall, 1'b0);
      tick();
      chk1("str_no_rf_we2", rf_we, 1'b0);

      // SUB, LDW, ADD back to back; ADD held by upstream while stalled
      drive(1'b1, OP_SUB, 32'd11, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      chk1("b2b_sub_we", rf_we, 1'b1);
      chk ("b2b_sub_waddr", 32'(rf_waddr), 32'd1);
      chk ("b2b_sub_wdata", rf_wdata, 32'd11);
      drive(1'b1, OP_LDW, 32'h0, 4'd2, 8'h30, 1'b0, 1'b0, 1'b0);
      tick();
      chk1("b2b_ldw_req", mem_req, 1'b1);
      chk1("b2b_ldw_no_we", rf_we, 1'b0);
      drive(1'b1, OP_ADD, 32'd44, 4'd4, 8'h00, 1'b0, 1'b1, 1'b0);
      #1 chk1("b2b_stall_wait", stall, 1'b1);
      mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      chk1("b2b_ldw_we", rf_we, 1'b1);
      chk ("b2b_ldw_waddr", 32'(rf_waddr), 32'd2);
      chk ("b2b_ldw_wdata", rf_wdata, 32'h0000_1234);
      chk1("b2b_stall_wb", stall, 1'b1);
      tick();
      chk1("b2b_add_ignored", rf_we, 1'b0);
      chk1("b2b_ovf_not_yet", status_ovf, 1'b0);
      chk1("b2b_stall_released", stall, 1'b0);
      tick();
      idle_in();
      chk1("b2b_add_we", rf_we, 1'b1);
      chk ("b2b_add_waddr", 32'(rf_waddr), 32'd4);
      chk ("b2b_add_wdata", rf_wdata, 32'd44);
      chk1("b2b_ovf_set", status_ovf, 1'b1);
      tick();
      chk1("ovf_sticky", status_ovf, 1'b1);

      // Reset during MEM_WAIT of a load, then a late ack
      drive(1'b1, OP_LDW, 32'h0, 4'd5, 8'h40, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      chk1("rstw_req", mem_req, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("rstw_req_drop", mem_req, 1'b0);
      chk1("rstw_no_we", rf_we, 1'b0);
      chk1("rstw_ovf_clr", status_ovf, 1'b0);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0; mem_rdata = '0;
      chk1("rstw_ack_ignored_req", mem_req, 1'b0);
      chk1("rstw_ack_ignored_we", rf_we, 1'b0);
      tick();
      chk1("rstw_no_we_late", rf_we, 1'b0);
      chk1("rstw_stall", stall, 1'b0);

      // Immediate load, branch, CMP with error flag, XOR with error flag
      drive(1'b1, OP_LDW, 32'd77, 4'd6, 8'h55, 1'b1, 1'b0, 1'b0);
      #1 chk1("ldi_stall", stall, 1'b0);
      tick();
      chk1("ldi_we", rf_we, 1'b1);
      chk ("ldi_waddr", 32'(rf_waddr), 32'd6);
      chk ("ldi_wdata", rf_wdata, 32'd77);
      chk1("ldi_no_req", mem_req, 1'b0);
      drive(1'b1, OP_BRQ, 32'd9, 4'd9, 8'h66, 1'b0, 1'b0, 1'b0);
      tick();
      chk1("brq_no_we", rf_we, 1'b0);
      chk1("brq_no_req", mem_req, 1'b0);
      drive(1'b1, OP_CMP, 32'd1, 4'd8, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk1("cmp_we", rf_we, 1'b1);
      chk ("cmp_waddr", 32'(rf_waddr), 32'd8);
      chk1("cmp_err_not_alu", status_err, 1'b0);
      drive(1'b1, OP_XOR, 32'h0F0F_0000, 4'd12, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      idle_in();
      chk ("xor_wdata", rf_wdata, 32'h0F0F_0000);
      chk1("xor_err_set", status_err, 1'b1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk1("idle_ack_no_req", mem_req, 1'b0);
      chk1("idle_ack_no_we", rf_we, 1'b0);

      // Store that is never acknowledged
      drive(1'b1, OP_STR, 32'd3, 4'd0, 8'h55, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      chk1("tmo_req_c1", mem_req, 1'b1);
`ifdef PIGRO_MEM_TIMEOUT_EN
      repeat (15) tick();
      chk1("tmo_req_c16", mem_req, 1'b1);
      chk1("tmo_bus_err_before", bus_error, 1'b0);
      tick();
      chk1("tmo_req_drop", mem_req, 1'b0);
      chk1("tmo_bus_err", bus_error, 1'b1);
      chk1("tmo_stall_idle", stall, 1'b0);
      chk1("tmo_no_we", rf_we, 1'b0);
`else
      repeat (30) tick();
      chk1("nto_req_held", mem_req, 1'b1);
      chk1("nto_bus_err", bus_error, 1'b0);
      chk1("nto_stall", stall, 1'b1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk1("nto_req_drop", mem_req, 1'b0);
`endif
      drive(1'b1, OP_ADD, 32'd9, 4'd10, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      idle_in();
      chk1("post_add_we", rf_we, 1'b1);
      chk ("post_add_waddr", 32'(rf_waddr), 32'd10);
      chk ("post_add_wdata", rf_wdata, 32'd9);
`ifdef PIGRO_MEM_TIMEOUT_EN
      chk1("tmo_bus_err_sticky", bus_error, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
